if_fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline. It owns the PC and issues word fetches to instruction memory over a req/ready handshake that tolerates wait states. It presents pc_4 and instruction to the decode stage, and honours the decode stage's stall (shouldStall) and redirect (shouldJumpOrBranch, jumpOrBranchPc) outputs. There are no branch delay slots: a redirect squashes the sequential fetch.

---
 rtl/if_fetch_stage.sv | 123 ++++++++++++
 tb/tb_if_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// Owns the PC and fetches words over a req/ready handshake with wait states.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        id_redirect,
  input  logic [31:0] id_redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic        if_valid,
  output logic [31:0] debug_pc
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_inc;
  logic [31:0] held_word, held_word_n;
  logic [31:0] stale_addr, stale_addr_n;
  logic [31:0] pc_4_n, instruction_n;
  logic        if_valid_n;
  logic        done;
  logic        req_n;
  logic [31:0] addr_n;

  assign done     = imem_req & imem_ready;
  assign pc_inc   = pc + 32'd4;
  assign debug_pc = pc;

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    held_word_n   = held_word;
    stale_addr_n  = stale_addr;
    pc_4_n        = pc_4;
    instruction_n = instruction;
    if_valid_n    = if_valid;
    unique case (1'b1)
      id_stall: begin
        if (state == FETCH && done) begin
          held_word_n = imem_rdata;
          state_n     = HOLD;
        end else if (state == SQUASH && done) begin
          state_n = FETCH;
        end
      end
      id_redirect && !id_stall: begin
        pc_4_n        = 32'd0;
        instruction_n = NOP_INSTR;
        if_valid_n    = 1'b0;
        pc_n          = {id_redirect_pc[31:2], 2'b00};
        unique case (state)
          // An issued request cannot be aborted, so wait it out.
          FETCH: begin
            if (imem_req && !done) begin
              stale_addr_n = {pc[31:2], 2'b00};
              state_n      = SQUASH;
            end
          end
          HOLD:    state_n = FETCH;
          SQUASH:  if (done) state_n = FETCH;
          default: state_n = FETCH;
        endcase
      end
      default: begin
        if (state == HOLD || (state == FETCH && done)) begin
          pc_4_n        = pc_inc;
          instruction_n = (state == HOLD) ? held_word : imem_rdata;
          if_valid_n    = 1'b1;
          pc_n          = pc_inc;
          state_n       = FETCH;
        end else begin
          pc_4_n        = 32'd0;
          instruction_n = NOP_INSTR;
          if_valid_n    = 1'b0;
          if (state == SQUASH && done) state_n = FETCH;
          else if (state != SQUASH) state_n = FETCH;
        end
      end
    endcase
  end

  assign req_n  = (state_n != HOLD);
  assign addr_n = (state_n == SQUASH) ? stale_addr_n
                                      : {pc_n[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      held_word   <= 32'd0;
      stale_addr  <= 32'd0;
      pc_4        <= 32'd0;
      instruction <= NOP_INSTR;
      if_valid    <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= {RESET_PC[31:2], 2'b00};
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      held_word   <= held_word_n;
      stale_addr  <= stale_addr_n;
      pc_4        <= pc_4_n;
      instruction <= instruction_n;
      if_valid    <= if_valid_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed plan, then random traffic
// scored against an architectural program-order model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic        id_redirect;
  logic [31:0] id_redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_4;
  logic [31:0] instruction;
  logic        if_valid;
  logic [31:0] debug_pc;

  int checks = 0;
  int failures = 0;
  int deliveries = 0;
  logic [31:0] junk = 32'h0;

  typedef struct packed {
    logic [31:0] pc_4;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] mpc;
  logic        last_stall = 1'b0;
  logic        mon_on = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0005;
      32'h4:   return 32'h2009_0003;
      32'h8:   return 32'h0109_5020;
      default: return (a * 32'h9E37_79B1) + 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_rdata = imem_ready ? word(imem_addr) : junk;

  if_fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .id_stall(id_stall),
    .id_redirect(id_redirect),
    .id_redirect_pc(id_redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .pc_4(pc_4),
    .instruction(instruction),
    .if_valid(if_valid),
    .debug_pc(debug_pc)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_pc4"}, pc_4, 32'd0);
    chk({tag, "_instr"}, instruction, 32'd0);
    chk({tag, "_pc"}, debug_pc, 32'd0);
  endtask

  // Monitor: pops expected deliveries and checks protocol/hold rules.
  logic        first = 1'b1;
  logic        p_req, p_ready, p_valid;
  logic [31:0] p_addr, p_pc4, p_instr;
  always @(negedge clk) begin
    if (mon_on) begin
      if (!first && p_req && !p_ready) begin
        chk("req_kept", {31'd0, imem_req}, 32'd1);
        chk("addr_stable", imem_addr, p_addr);
      end
      chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (!first && last_stall) begin
        chk("stall_pc4", pc_4, p_pc4);
        chk("stall_instr", instruction, p_instr);
        chk("stall_valid", {31'd0, if_valid}, {31'd0, p_valid});
      end else if (if_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery: pc_4 %h with empty queue",
                   pc_4);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("deliver_pc4", pc_4, e.pc_4);
          chk("deliver_instr", instruction, e.instr);
          deliveries++;
        end
      end else begin
        chk("bubble_pc4", pc_4, 32'd0);
        chk("bubble_instr", instruction, 32'd0);
      end
      first   = 1'b0;
      p_req   = imem_req;
      p_ready = imem_ready;
      p_addr  = imem_addr;
      p_pc4   = pc_4;
      p_instr = instruction;
      p_valid = if_valid;
    end
  end

  initial begin
    rst = 1'b1;
    id_stall = 1'b0;
    id_redirect = 1'b0;
    id_redirect_pc = 32'd0;
    imem_ready = 1'b1;
    #3;
    chk_reset("rst0");
    #5;
    rst = 1'b0;
    tick();
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick();
    chk("t1_instr0", instruction, 32'h2008_0005);
    chk("t1_pc4_0", pc_4, 32'h4);
    chk("t1_valid0", {31'd0, if_valid}, 32'd1);
    chk("t1_addr4", imem_addr, 32'h4);
    tick();
    chk("t1_instr1", instruction, 32'h2009_0003);
    chk("t1_pc4_1", pc_4, 32'h8);
    imem_ready = 1'b0;
    tick();
    chk("t2_bub1", {31'd0, if_valid}, 32'd0);
    chk("t2_bub1_instr", instruction, 32'd0);
    chk("t2_addr", imem_addr, 32'h8);
    tick();
    chk("t2_bub2", {31'd0, if_valid}, 32'd0);
    chk("t2_addr2", imem_addr, 32'h8);
    imem_ready = 1'b1;
    tick();
    chk("t2_instr", instruction, 32'h0109_5020);
    chk("t2_pc4", pc_4, 32'hC);
    id_stall = 1'b1;
    tick();
    chk("t3_req_drop", {31'd0, imem_req}, 32'd0);
    chk("t3_hold1", instruction, 32'h0109_5020);
    tick();
    tick();
    chk("t3_hold3", instruction, 32'h0109_5020);
    chk("t3_hold3_pc4", pc_4, 32'hC);
    id_stall = 1'b0;
    tick();
    chk("t3_instr", instruction, word(32'hC));
    chk("t3_pc4", pc_4, 32'h10);
    chk("t3_addr", imem_addr, 32'h10);
    id_redirect = 1'b1;
    id_redirect_pc = 32'h40;
    tick();
    chk("t4_bubble", {31'd0, if_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h40);
    id_redirect = 1'b0;
    tick();
    chk("t4_pc4", pc_4, 32'h44);
    chk("t4_instr", instruction, word(32'h40));
    id_redirect = 1'b1;
    id_redirect_pc = 32'h10;
    tick();
    id_redirect_pc = 32'h103;
    imem_ready = 1'b0;
    tick();
    chk("t5_addr_stale", imem_addr, 32'h10);
    chk("t5_pc", debug_pc, 32'h100);
    id_redirect = 1'b0;
    tick();
    chk("t5_addr_wait", imem_addr, 32'h10);
    imem_ready = 1'b1;
    tick();
    chk("t5_discard", {31'd0, if_valid}, 32'd0);
    chk("t5_addr_new", imem_addr, 32'h100);
    tick();
    chk("t5_pc4", pc_4, 32'h104);
    chk("t5_instr", instruction, word(32'h100));
    id_redirect = 1'b1;
    id_redirect_pc = 32'h24;
    tick();
    id_redirect = 1'b0;
    imem_ready = 1'b0;
    tick();
    chk("t6_wait_addr", imem_addr, 32'h24);
    rst = 1'b1;
    #1;
    chk_reset("t6_async");
    #1;
    rst = 1'b0;
    imem_ready = 1'b1;
    tick();
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    id_redirect = 1'b1;
    id_redirect_pc = 32'hFFFF_FFFC;
    tick();
    id_redirect = 1'b0;
    chk("t6_wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_valid", {31'd0, if_valid}, 32'd1);
    chk("t6_wrap_pc4", pc_4, 32'h0);
    chk("t6_wrap_instr", instruction, word(32'hFFFF_FFFC));
    chk("t6_wrap_next", imem_addr, 32'h0);

    // Random phase from a clean reset.
    rst = 1'b1;
    imem_ready = 1'b0;
    #2;
    rst = 1'b0;
    exp_q.delete();
    mpc = 32'd0;
    last_stall = 1'b0;
    mon_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      last_stall = id_stall;
      if (!id_stall && id_redirect) begin
        exp_q.delete();
        mpc = {id_redirect_pc[31:2], 2'b00};
      end
      if (exp_q.size() == 0) begin
        exp_q.push_back('{pc_4: mpc + 32'd4, instr: word(mpc)});
        mpc = mpc + 32'd4;
      end
      imem_ready = ($urandom_range(9) < 7);
      id_stall = ($urandom_range(9) < 2);
      id_redirect = ($urandom_range(11) == 0);
      id_redirect_pc = ($urandom_range(3) == 0)
                       ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                       : $urandom;
      junk = $urandom;
    end
    @(negedge clk);
    mon_on = 1'b0;
    checks++;
    if (deliveries < 300) begin
      failures++;
      $display("FAIL throughput: got %0d deliveries expected >= 300",
               deliveries);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
